// File: rtl/mdu_pkg.sv
// Shared op encodings, default latencies and decode helpers for the MDU.
// MDU_MADD_EN enables the MADD/MADDU accumulate ops (7/8); otherwise they decode as NONE.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MADD  = 4'd7,
        MDU_MADDU = 4'd8
    } mdu_op_e;

    localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
    localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

    function automatic int unsigned mdu_cnt_width(int unsigned mult_cycles, int unsigned div_cycles);
        int unsigned m;
        m = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return $clog2(m + 1);
    endfunction

    function automatic logic mdu_is_mul(logic [3:0] op);
        logic r;
        r = (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_MADD_EN
        r = r || (op == MDU_MADD) || (op == MDU_MADDU);
`endif
        return r;
    endfunction

    function automatic logic mdu_is_div(logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// E-stage <-> MDU connection: decoded op/operands/flush in, stall and HI/LO out.
interface mdu_sequencer_if;

    logic [3:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        cancel;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output op, rs_val, rt_val, cancel,
        input  busy, stall_req, hi, lo
    );

    modport slave (
        input  op, rs_val, rt_val, cancel,
        output busy, stall_req, hi, lo
    );

endinterface

// File: rtl/mdu_arith.sv
// Combinational HI/LO result generator; divide-by-zero and NONE leave HI/LO untouched (wr_en=0).
// MDU_MADD_EN adds the {HI,LO} += rs*rt accumulate ops.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] hi_nxt,
    output logic [31:0] lo_nxt,
    output logic        wr_en
);

    logic        mul_signed;
    logic        div_signed;
    logic [63:0] rs_x;
    logic [63:0] rt_x;
    logic [63:0] prod;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic        q_neg;

    // Division runs on magnitudes so INT_MIN / -1 wraps to 0x80000000 without signed overflow.
    always_comb begin
        mul_signed = (op == MDU_MULT) || (op == MDU_MADD);
        div_signed = (op == MDU_DIV);
        rs_x = mul_signed ? {{32{rs[31]}}, rs} : {32'b0, rs};
        rt_x = mul_signed ? {{32{rt[31]}}, rt} : {32'b0, rt};
        prod = rs_x * rt_x;

        a_mag = (div_signed && rs[31]) ? (32'd0 - rs) : rs;
        b_mag = (div_signed && rt[31]) ? (32'd0 - rt) : rt;
        q_mag = (b_mag == '0) ? '0 : (a_mag / b_mag);
        r_mag = (b_mag == '0) ? '0 : (a_mag % b_mag);
        q_neg = div_signed && (rs[31] ^ rt[31]);
    end

    always_comb begin
        hi_nxt = hi;
        lo_nxt = lo;
        wr_en  = 1'b0;
        case (op)
            MDU_MULT, MDU_MULTU: begin
                {hi_nxt, lo_nxt} = prod;
                wr_en = 1'b1;
            end
            MDU_DIV, MDU_DIVU: begin
                lo_nxt = q_neg ? (32'd0 - q_mag) : q_mag;
                hi_nxt = (div_signed && rs[31]) ? (32'd0 - r_mag) : r_mag;
                wr_en  = (rt != '0);
            end
            MDU_MTHI: begin
                hi_nxt = rs;
                wr_en  = 1'b1;
            end
            MDU_MTLO: begin
                lo_nxt = rs;
                wr_en  = 1'b1;
            end
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU: begin
                {hi_nxt, lo_nxt} = {hi, lo} + prod;
                wr_en = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/DIV sequencer owning HI/LO; a busy counter models fixed latency.
// MDU_MADD_EN (see mdu_pkg) enables MADD/MADDU.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    mdu_sequencer_if.slave mdu
);

    localparam int unsigned CW = mdu_cnt_width(MULT_CYCLES, DIV_CYCLES);
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   hs_q, hs_d;
    logic [31:0]   ls_q, ls_d;
    logic          ws_q, ws_d;

    logic [31:0]   hi_nxt;
    logic [31:0]   lo_nxt;
    logic          wr_en;
    logic          is_mul;
    logic          is_div;

    mdu_arith u_arith (
        .op     (mdu.op),
        .rs     (mdu.rs_val),
        .rt     (mdu.rt_val),
        .hi     (hi_q),
        .lo     (lo_q),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt),
        .wr_en  (wr_en)
    );

    assign is_mul = mdu_is_mul(mdu.op);
    assign is_div = mdu_is_div(mdu.op);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            hs_q    <= '0;
            ls_q    <= '0;
            ws_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hs_q    <= hs_d;
            ls_q    <= ls_d;
            ws_q    <= ws_d;
        end
    end

    // Long ops stage their result at accept; MTHI/MTLO write through in the same edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hs_d    = hs_q;
        ls_d    = ls_q;
        ws_d    = ws_q;
        case (state_q)
            S_IDLE: begin
                if (!mdu.cancel) begin
                    if (is_mul || is_div) begin
                        hs_d    = hi_nxt;
                        ls_d    = lo_nxt;
                        ws_d    = wr_en;
                        cnt_d   = is_div ? DIV_LD : MULT_LD;
                        state_d = S_RUN;
                    end else if (wr_en) begin
                        hi_d = hi_nxt;
                        lo_d = lo_nxt;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_IDLE;
                    if (ws_q) begin
                        hi_d = hs_q;
                        lo_d = ls_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mdu.busy      = (state_q == S_RUN);
    assign mdu.stall_req = mdu.busy || is_mul || is_div;
    assign mdu.hi        = hi_q;
    assign mdu.lo        = lo_q;

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide sequencer owning the HI/LO registers.
- Sits in the E stage beside the ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the decoded op field and models the fixed MULT/DIV latency with a busy counter.
- Drives the stall request to the hazard unit and exposes HI/LO for MFHI/MFLO forwarding.
- Honours the exception/interrupt flush so a cancelled instruction never touches HI/LO.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (and MADD/MADDU when enabled); must be >= 1.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  4  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU; others NONE.
- rs_val  in  32  forwarded rs operand.
- rt_val  in  32  forwarded rt operand.
- cancel  in  1  flush of the E-stage instruction this cycle (exception, interrupt or eret).
- busy  out  1  operation in flight.
- stall_req  out  1  busy OR (op in {1,2,3,4,7,8}) OR (busy-blocked MTHI/MTLO); combinational.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (async, reset_n=0): hi=0, lo=0, busy=0, counter=0, staging registers=0. Takes effect immediately, including mid-operation; an in-flight result is discarded.
- Accept condition: op valid, busy=0, cancel=0.
  - At that edge, compute the result combinationally from rs_val/rt_val and latch it into staging registers hi_nxt/lo_nxt.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
- States:
  - IDLE (counter=0): busy=0.
  - RUN (counter>0): busy=1; counter decrements each edge.
  - On the edge where counter==1: hi<=hi_nxt, lo<=lo_nxt, counter<=0. busy falls and the new HI/LO become visible in the same cycle.
- Latency: busy is high for exactly N cycles after the accept edge.
- Ops while busy:
  - All ops are ignored, including MTHI/MTLO.
  - stall_req stays high, so the pipeline holds the instruction.
  - No queuing.
- MTHI/MTLO: when idle and not cancelled, hi (or lo) <= rs_val at the next edge. Zero latency; busy stays 0.
- cancel=1: any op in the same cycle is ignored. cancel does not abort an operation already in RUN; that instruction has already committed past E.
- Arithmetic:
  - MULT: signed 32x32 to 64; HI=upper 32 bits, LO=lower 32 bits.
  - MULTU: unsigned 32x32 to 64; HI=upper 32 bits, LO=lower 32 bits.
  - DIV: signed; LO=quotient truncated toward zero; HI=remainder with the dividend's sign.
  - DIVU: unsigned; LO=quotient, HI=remainder.
  - Divisor==0: the op is still accepted and busy runs DIV_CYCLES; HI/LO remain unchanged at completion.
  - DIV 0x80000000/-1: LO=0x80000000, HI=0.
- Simultaneous completion edge and new op: the new op sees busy=1 and is ignored that cycle. It is accepted on the following cycle.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: op 7 MADD computes {HI,LO} += signed rs*rt; op 8 MADDU computes {HI,LO} += unsigned rs*rt. Both take MULT_CYCLES and sample the current HI/LO at the accept edge.
- Undefined: ops 7/8 decode as NONE, with no stall and no state change.

Decomposition:
- Package mdu_pkg:
  - op encoding constants MDU_NONE..MDU_MADDU;
  - default cycle counts;
  - counter width function clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- Sub-module mdu_arith: purely combinational, (op, rs, rt, hi, lo) to (hi_nxt, lo_nxt, wr_en). It keeps the arithmetic and divide-by-zero rules apart from the counter/FSM.

Test Plan:
- Reset: reset_n=0 mid-DIV (counter=6) -> busy=0, hi=lo=0 immediately; no write after release.
- MULT rs=0xFFFFFFFD, rt=7 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFEB; stall_req high on issue cycle and all busy cycles.
- DIVU 100/7 -> busy 10 cycles, lo=14, hi=2. DIV 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV x/0 -> busy 10 cycles, hi/lo unchanged.
- MTHI 0x1234 while busy -> ignored and stall_req=1. Same MTHI when idle -> hi=0x1234 next edge, busy stays 0.
- MULT with cancel=1 -> busy stays 0, hi/lo unchanged. cancel pulsed during RUN -> operation still completes normally.
- MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU 1*1 -> hi=1, lo=0 after 5 cycles. Macro undefined -> op 8 gives no busy and no stall.
